psram_resp: RTL and testbench
=============================

PSRAM_RESP -- requirements
Module: psram_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, giving the internal byte array size (power of two, 16..4096).
REQ-002 SHALL have parameter RLC, default 8'd5, giving the read latency in SCK cycles after the address phase.
REQ-003 SHALL have parameter WLC, default 8'd5, giving the array-write latency in SCK cycles after the address phase.
REQ-004 SHALL have parameter VID, default 8'h0D, giving the reset value of MR1 (vendor id).
REQ-005 SHALL have these ports: clk_i  in  1  system clock; the only clock.
REQ-006 SHALL have: rst_i  in  1  reset, synchronous and active-high.
REQ-007 SHALL have: psram_sck_i  in  1  bus clock, oversampled.
REQ-008 SHALL have: psram_ce_i  in  1  chip enable, active-low.
REQ-009 SHALL have: psram_io_in_i  in  8  octal data from the controller.
REQ-010 SHALL have: psram_io_out_o  out  8; psram_io_en_o  out  1  (1 = responder drives IO).
REQ-011 SHALL have: psram_dqs_in_i  in  1  write mask (1 = write the byte).
REQ-012 SHALL have: psram_dqs_out_o  out  1  read strobe; psram_dqs_en_o  out  1.
REQ-013 SHALL have: busy_o  out  1  (CE asserted); cmd_err_o  out  1  (one-clk pulse on an unknown or mismatched command).

Function
REQ-014 SHALL register sck, ce, io and dqs once in clk_i; a "beat" is a registered-sck rising edge while registered ce=0; clk_i >= 4x sck is required.
REQ-015 SHALL use FSM states IDLE, CMD, ADDR, LATN, WDATA, RDATA, DROP.
REQ-016 SHALL move IDLE->CMD on registered-ce falling edge.
REQ-017 CMD SHALL capture 2 beats; byte1 != byte0 or an unknown opcode -> DROP and pulse cmd_err_o.
REQ-018 SHALL decode opcodes: 8'h00 array read, 8'h80 array write, 8'h40 reg read, 8'hC0 reg write, 8'hFF global reset.
REQ-019 ADDR SHALL shift in 4 beats MSB first; array address = addr mod DEPTH, reg index = addr[2:0].
REQ-020 After ADDR: array read / reg read / array write -> LATN (counter = RLC, RLC, WLC); reg write -> WDATA directly; global reset -> DROP, with MR reset to defaults when CE rises.
REQ-021 LATN SHALL count down 1 per beat and leave on the beat where the count is 0; latency 0 leaves on the first beat.
REQ-022 RDATA, each beat: io_out = mem[ptr] (or MR[idx]), dqs_out = 1 for that beat, then dqs_out = 0 at the next sck fall; ptr increments and wraps at DEPTH-1 -> 0; reg read repeats MR[idx].
REQ-023 psram_io_en_o and psram_dqs_en_o SHALL be 1 only in RDATA.
REQ-024 WDATA, each beat: if dqs_in = 1, write io byte to mem[ptr]; ptr increments with wrap regardless of the mask.
REQ-025 Reg write SHALL write the first data byte only; later bytes are ignored.
REQ-026 CE rising in any state SHALL return to IDLE on the next clk, dropping an in-progress byte.
REQ-027 CE falling and an sck edge on the same clk: the CE edge is processed first, and the sck edge counts as the first beat.
REQ-028 Array contents SHALL be unaffected by CE aborts.

Reset
REQ-029 rst_i SHALL force: FSM=IDLE; all outputs 0; counters and pointer 0; MR0=0, MR1=VID, MR2..MR7=0.
REQ-030 The array SHALL NOT be reset (contents undefined).

Configuration
REQ-031 PSRAM_RESP_MR_EN defined: reg read/write and global reset are implemented as specified.
REQ-032 PSRAM_RESP_MR_EN undefined: opcodes 40/C0/FF are treated as unknown (DROP + cmd_err_o), and the MR storage is absent.

Structure
REQ-033 psram_resp_pkg SHALL hold the FSM state enum, opcode constants and MR defaults.
REQ-034 Sub-module psram_resp_mem SHALL be the byte array: 1 write port, 1 async-read port, DEPTH parameter.

Verification
REQ-035 Cmd 00 00, addr 00000010, RLC=5, 8 read beats, mem[10..17]=11..88 -> io_out 11..88, one dqs pulse per beat, io_en only in RDATA.
REQ-036 Cmd 80 80, addr FE, WLC=5, data AA BB CC, dqs 1,0,1 -> mem[FE]=AA, mem[FF] unchanged, mem[00]=CC (wrap).
REQ-037 Cmd C0 C0, addr 02, data 5A 77 then reg read 40 40 addr 02 -> returns 5A; with MR_EN undefined -> cmd_err_o pulse, no drive.
REQ-038 Cmd 80 81 -> cmd_err_o pulse, DROP, no array writes until CE high.
REQ-039 CE high after 2 address beats, then a full read -> IDLE on the next clk, and the new transfer decodes correctly.
REQ-040 rst_i asserted mid-RDATA -> next clk io_en=0, dqs_out=0, FSM IDLE, MR1=0D.

Source files
------------

// File: rtl/psram_resp_pkg.sv
// Shared types and constants for the octal PSRAM responder model: FSM states,
// decoded operations, opcodes and mode-register reset values.
package psram_resp_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StLatn,
        StWdata,
        StRdata,
        StDrop
    } state_e;

    typedef enum logic [2:0] {
        OpArrRd,
        OpArrWr,
        OpRegRd,
        OpRegWr,
        OpGrst,
        OpBad
    } op_e;

    localparam logic [7:0] OpcArrRd = 8'h00;
    localparam logic [7:0] OpcArrWr = 8'h80;
    localparam logic [7:0] OpcRegRd = 8'h40;
    localparam logic [7:0] OpcRegWr = 8'hC0;
    localparam logic [7:0] OpcGrst  = 8'hFF;

    localparam logic [2:0] MrVidIdx  = 3'd1;
    localparam logic [7:0] MrDefault = 8'h00;

    // MR1 carries the vendor id; every other mode register resets to zero.
    function automatic logic [7:0] mr_default(input logic [2:0] idx, input logic [7:0] vid);
        return (idx == MrVidIdx) ? vid : MrDefault;
    endfunction

endpackage

// File: rtl/psram_resp_mem.sv
// Byte array behind the PSRAM responder: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module psram_resp_mem #(
    parameter int unsigned DEPTH = 256
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [7:0]               wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [7:0]               rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/psram_resp.sv
// Octal PSRAM responder with an oversampled bus clock. Mode registers, register
// read/write and global reset exist only when PSRAM_RESP_MR_EN is defined.
module psram_resp
    import psram_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter logic [7:0]  RLC   = 8'd5,
    parameter logic [7:0]  WLC   = 8'd5,
    parameter logic [7:0]  VID   = 8'h0D
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       psram_sck_i,
    input  logic       psram_ce_i,
    input  logic [7:0] psram_io_in_i,
    output logic [7:0] psram_io_out_o,
    output logic       psram_io_en_o,
    input  logic       psram_dqs_in_i,
    output logic       psram_dqs_out_o,
    output logic       psram_dqs_en_o,
    output logic       busy_o,
    output logic       cmd_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic          sck_q, sck_prev_q, ce_q, ce_prev_q, dqs_q, busy_q;
    logic [7:0]    io_q;
    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    byte0_q, byte0_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [2:0]    idx_q, idx_d;
    logic          grst_q, grst_d;
    logic          mr_wr_done_q, mr_wr_done_d;
    logic [7:0]    io_out_q, io_out_d;
    logic          dqs_out_q, dqs_out_d;
    logic          cmd_err_q, cmd_err_d;
    logic          mem_we, mr_we, mr_rst;
    logic [7:0]    mem_rdata, mr_rdata;
    logic          beat, sck_fall, ce_fall;

    assign beat     = sck_q & ~sck_prev_q & ~ce_q;
    assign sck_fall = ~sck_q & sck_prev_q;
    assign ce_fall  = ce_prev_q & ~ce_q;

    function automatic op_e decode_op(input logic [7:0] opc);
        op_e op;
        op = OpBad;
        case (opc)
            OpcArrRd: op = OpArrRd;
            OpcArrWr: op = OpArrWr;
`ifdef PSRAM_RESP_MR_EN
            OpcRegRd: op = OpRegRd;
            OpcRegWr: op = OpRegWr;
            OpcGrst:  op = OpGrst;
`endif
            default:  op = OpBad;
        endcase
        return op;
    endfunction

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        byte0_d      = byte0_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        grst_d       = grst_q;
        mr_wr_done_d = mr_wr_done_q;
        io_out_d     = io_out_q;
        dqs_out_d    = dqs_out_q;
        cmd_err_d    = 1'b0;
        mem_we       = 1'b0;
        mr_we        = 1'b0;
        mr_rst       = 1'b0;

        if (sck_fall) begin
            dqs_out_d = 1'b0;
        end

        if (ce_q) begin
            // CE high aborts everything; a pending global reset lands here.
            if (state_q != StIdle) begin
                state_d = StIdle;
                mr_rst  = grst_q;
            end
            grst_d    = 1'b0;
            dqs_out_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ce_fall) begin
                        state_d      = StCmd;
                        cnt_d        = 8'd0;
                        mr_wr_done_d = 1'b0;
                        if (beat) begin
                            byte0_d = io_q;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                StCmd: begin
                    if (beat) begin
                        if (cnt_q == 8'd0) begin
                            byte0_d = io_q;
                            cnt_d   = 8'd1;
                        end else begin
                            cnt_d = 8'd0;
                            if (io_q != byte0_q || decode_op(byte0_q) == OpBad) begin
                                state_d   = StDrop;
                                cmd_err_d = 1'b1;
                            end else begin
                                op_d    = decode_op(byte0_q);
                                state_d = StAddr;
                            end
                        end
                    end
                end
                StAddr: begin
                    if (beat) begin
                        // Shifting into an AW-bit pointer yields addr mod DEPTH directly.
                        ptr_d = AW'({ptr_q, io_q});
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == 8'd3) begin
                            idx_d = io_q[2:0];
                            case (op_q)
                                OpArrRd, OpRegRd: begin
                                    state_d = StLatn;
                                    cnt_d   = RLC;
                                end
                                OpArrWr: begin
                                    state_d = StLatn;
                                    cnt_d   = WLC;
                                end
                                OpRegWr: state_d = StWdata;
                                OpGrst: begin
                                    state_d = StDrop;
                                    grst_d  = 1'b1;
                                end
                                default: state_d = StDrop;
                            endcase
                        end
                    end
                end
                StLatn: begin
                    if (beat) begin
                        if (cnt_q == 8'd0) begin
                            state_d = (op_q == OpArrWr) ? StWdata : StRdata;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                StWdata: begin
                    if (beat) begin
                        if (op_q == OpRegWr) begin
                            mr_we        = ~mr_wr_done_q;
                            mr_wr_done_d = 1'b1;
                        end else begin
                            mem_we = dqs_q;
                            ptr_d  = ptr_q + {{(AW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                StRdata: begin
                    if (beat) begin
                        io_out_d  = (op_q == OpRegRd) ? mr_rdata : mem_rdata;
                        dqs_out_d = 1'b1;
                        if (op_q != OpRegRd) begin
                            ptr_d = ptr_q + {{(AW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                StDrop: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // CE resets low so a CE held low through reset is not seen as a new edge.
            sck_q        <= 1'b0;
            sck_prev_q   <= 1'b0;
            ce_q         <= 1'b0;
            ce_prev_q    <= 1'b0;
            io_q         <= 8'h00;
            dqs_q        <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
            op_q         <= OpArrRd;
            cnt_q        <= 8'd0;
            byte0_q      <= 8'h00;
            ptr_q        <= '0;
            idx_q        <= 3'd0;
            grst_q       <= 1'b0;
            mr_wr_done_q <= 1'b0;
            io_out_q     <= 8'h00;
            dqs_out_q    <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            sck_q        <= psram_sck_i;
            sck_prev_q   <= sck_q;
            ce_q         <= psram_ce_i;
            ce_prev_q    <= ce_q;
            io_q         <= psram_io_in_i;
            dqs_q        <= psram_dqs_in_i;
            busy_q       <= ~ce_q;
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            byte0_q      <= byte0_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            grst_q       <= grst_d;
            mr_wr_done_q <= mr_wr_done_d;
            io_out_q     <= io_out_d;
            dqs_out_q    <= dqs_out_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

`ifdef PSRAM_RESP_MR_EN
    logic [7:0] mr_q [8];

    always_ff @(posedge clk_i) begin
        if (rst_i || mr_rst) begin
            for (int i = 0; i < 8; i++) begin
                mr_q[i] <= mr_default(3'(i), VID);
            end
        end else if (mr_we) begin
            mr_q[idx_q] <= io_q;
        end
    end

    assign mr_rdata = mr_q[idx_q];
`else
    logic unused_mr;
    assign unused_mr = mr_we ^ mr_rst ^ (^idx_q) ^ (^VID);
    assign mr_rdata  = 8'h00;
`endif

    psram_resp_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk_i  (clk_i),
        .we_i   (mem_we),
        .waddr_i(ptr_q),
        .wdata_i(io_q),
        .raddr_i(ptr_q),
        .rdata_o(mem_rdata)
    );

    assign psram_io_out_o  = io_out_q;
    assign psram_dqs_out_o = dqs_out_q;
    assign psram_io_en_o   = (state_q == StRdata);
    assign psram_dqs_en_o  = (state_q == StRdata);
    assign busy_o          = busy_q;
    assign cmd_err_o       = cmd_err_q;

endmodule

// File: tb/tb_psram_resp.sv
// Self-checking bench for psram_resp: transactions are built as beat lists and
// checked against an array/mode-register model derived from the bus protocol.
`timescale 1ns/1ps
module tb_psram_resp;

    localparam int unsigned DEPTH  = 256;
    localparam int          RLC    = 5;
    localparam int          WLC    = 5;
    localparam int          RD_OFS = 6 + RLC + 1;
    localparam int          WR_OFS = 6 + WLC + 1;
    localparam int          RW_OFS = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       ce  = 1'b1;
    logic [7:0] io_in = 8'h00;
    logic       dqs_in = 1'b0;
    logic [7:0] io_out;
    logic       io_en, dqs_out, dqs_en, busy, cmd_err;

    psram_resp #(
        .DEPTH(DEPTH),
        .RLC  (8'(RLC)),
        .WLC  (8'(WLC)),
        .VID  (8'h0D)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .psram_sck_i    (sck),
        .psram_ce_i     (ce),
        .psram_io_in_i  (io_in),
        .psram_io_out_o (io_out),
        .psram_io_en_o  (io_en),
        .psram_dqs_in_i (dqs_in),
        .psram_dqs_out_o(dqs_out),
        .psram_dqs_en_o (dqs_en),
        .busy_o         (busy),
        .cmd_err_o      (cmd_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int err_hi = 0;

    always @(posedge clk) if (cmd_err) err_hi <= err_hi + 1;

    // Reference model
    logic [7:0] mdl [DEPTH];
    bit         known [DEPTH];
    logic [7:0] mr_mdl [8];

    // Beat lists for one transaction
    logic [7:0] tx_d [$];
    logic       tx_m [$];
    logic [7:0] rx_d [$];
    logic       rx_hi [$];
    logic       rx_lo [$];
    logic       rx_en [$];
    logic       rx_busy [$];
    logic       post_drive;
    logic       post_busy;

    task automatic clr();
        tx_d.delete(); tx_m.delete();
    endtask

    task automatic push(input logic [7:0] d, input logic m);
        tx_d.push_back(d); tx_m.push_back(m);
    endtask

    task automatic hdr(input logic [7:0] c0, input logic [7:0] c1, input logic [31:0] a,
                       input int nlat);
        push(c0, 1'b0); push(c1, 1'b0);
        for (int i = 3; i >= 0; i--) push(a[8*i +: 8], 1'b0);
        for (int i = 0; i < nlat; i++) push(8'h00, 1'b0);
    endtask

    task automatic bus_beat(input logic [7:0] d, input logic m, input bit ce_too);
        @(negedge clk);
        io_in = d; dqs_in = m; sck = 1'b1;
        if (ce_too) ce = 1'b0;
        repeat (4) @(negedge clk);
        rx_d.push_back(io_out);
        rx_hi.push_back(dqs_out);
        rx_en.push_back(io_en | dqs_en);
        rx_busy.push_back(busy);
        sck = 1'b0;
        repeat (4) @(negedge clk);
        rx_lo.push_back(dqs_out);
    endtask

    task automatic run_xfer(input bit same_edge);
        rx_d.delete(); rx_hi.delete(); rx_lo.delete(); rx_en.delete(); rx_busy.delete();
        if (!same_edge) begin
            @(negedge clk); ce = 1'b0;
            repeat (2) @(negedge clk);
        end
        foreach (tx_d[i]) bus_beat(tx_d[i], tx_m[i], same_edge && (i == 0));
        @(negedge clk); ce = 1'b1;
        repeat (3) @(negedge clk);
        post_drive = io_en | dqs_en | dqs_out;
        post_busy  = busy;
    endtask

    task automatic arr_write(input logic [31:0] a, input logic [7:0] d [$], input logic m [$]);
        int base;
        clr();
        hdr(8'h80, 8'h80, a, WLC + 1);
        foreach (d[i]) push(d[i], m[i]);
        run_xfer(1'b0);
        base = int'(a % DEPTH);
        foreach (d[i]) if (m[i]) begin
            mdl[(base + i) % DEPTH]   = d[i];
            known[(base + i) % DEPTH] = 1'b1;
        end
    endtask

    task automatic arr_read(input logic [31:0] a, input int n, input bit same_edge);
        clr();
        hdr(8'h00, 8'h00, a, RLC + 1);
        for (int i = 0; i < n; i++) push(8'h00, 1'b0);
        run_xfer(same_edge);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (io_out !== 8'h00) begin n_bad++; $display("FAIL rst_io_out got %h want 00", io_out); end
        n_cmp++; if (io_en !== 1'b0) begin n_bad++; $display("FAIL rst_io_en got %b want 0", io_en); end
        n_cmp++; if (dqs_out !== 1'b0) begin n_bad++; $display("FAIL rst_dqs_out got %b want 0", dqs_out); end
        n_cmp++; if (dqs_en !== 1'b0) begin n_bad++; $display("FAIL rst_dqs_en got %b want 0", dqs_en); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_err got %b want 0", cmd_err); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_array_read();
        logic [7:0] d [$];
        logic       m [$];
        int         e0;
        for (int i = 0; i < 8; i++) begin d.push_back(8'(8'h11 * (i + 1))); m.push_back(1'b1); end
        arr_write(32'h0000_0010, d, m);
        e0 = err_hi;
        arr_read(32'h0000_0010, 8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (rx_d[RD_OFS+i] !== mdl[16+i]) begin n_bad++;
                $display("FAIL rd_data[%0d] got %h want %h", i, rx_d[RD_OFS+i], mdl[16+i]); end
            n_cmp++; if (rx_hi[RD_OFS+i] !== 1'b1 || rx_lo[RD_OFS+i] !== 1'b0) begin n_bad++;
                $display("FAIL rd_dqs[%0d] got %b%b want 10", i, rx_hi[RD_OFS+i], rx_lo[RD_OFS+i]); end
            n_cmp++; if (rx_en[RD_OFS+i] !== 1'b1) begin n_bad++;
                $display("FAIL rd_en[%0d] got %b want 1", i, rx_en[RD_OFS+i]); end
        end
        for (int i = 0; i < RD_OFS - 1; i++) begin
            n_cmp++; if (rx_en[i] !== 1'b0 || rx_hi[i] !== 1'b0) begin n_bad++;
                $display("FAIL pre_rd_drive[%0d] got en=%b dqs=%b want 0", i, rx_en[i], rx_hi[i]); end
        end
        n_cmp++; if (rx_busy[0] !== 1'b1) begin n_bad++; $display("FAIL busy_active got %b want 1", rx_busy[0]); end
        n_cmp++; if (post_drive !== 1'b0 || post_busy !== 1'b0) begin n_bad++;
            $display("FAIL rd_post got drive=%b busy=%b want 0 0", post_drive, post_busy); end
        n_cmp++; if (err_hi != e0) begin n_bad++; $display("FAIL rd_no_err got %0d want 0", err_hi - e0); end
    endtask

    task automatic test_wrap_write();
        logic [7:0] d [$];
        logic       m [$];
        d = '{8'h5C}; m = '{1'b1};
        arr_write(32'h0000_00FF, d, m);
        d = '{8'hAA, 8'hBB, 8'hCC}; m = '{1'b1, 1'b0, 1'b1};
        arr_write(32'h0000_00FE, d, m);
        arr_read(32'h0000_00FE, 3, 1'b0);
        n_cmp++; if (rx_d[RD_OFS] !== 8'hAA) begin n_bad++; $display("FAIL wrap_fe got %h want aa", rx_d[RD_OFS]); end
        n_cmp++; if (rx_d[RD_OFS+1] !== 8'h5C) begin n_bad++; $display("FAIL wrap_ff got %h want 5c", rx_d[RD_OFS+1]); end
        n_cmp++; if (rx_d[RD_OFS+2] !== 8'hCC) begin n_bad++; $display("FAIL wrap_00 got %h want cc", rx_d[RD_OFS+2]); end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] d [$];
        logic       m [$];
        logic [7:0] opc [3];
        int         e0;
        for (int i = 0; i < 4; i++) begin d.push_back(8'($urandom)); m.push_back(1'b1); end
        arr_write(32'h0000_0040, d, m);
        opc[0] = 8'h81; opc[1] = 8'h12; opc[2] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            e0 = err_hi;
            clr();
            hdr((k == 1) ? 8'h12 : 8'h80, opc[k] ^ ((k == 2) ? 8'h01 : 8'h00), 32'h40, WLC + 1);
            for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i), 1'b1);
            run_xfer(1'b0);
            n_cmp++; if (err_hi - e0 != 1) begin n_bad++; $display("FAIL bad_cmd%0d_err got %0d want 1", k, err_hi - e0); end
            foreach (rx_en[i]) begin
                n_cmp++; if (rx_en[i] !== 1'b0) begin n_bad++; $display("FAIL bad_cmd%0d_en[%0d] got 1 want 0", k, i); end
            end
        end
        arr_read(32'h0000_0040, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rx_d[RD_OFS+i] !== mdl[64+i]) begin n_bad++;
                $display("FAIL bad_cmd_mem[%0d] got %h want %h", i, rx_d[RD_OFS+i], mdl[64+i]); end
        end
    endtask

    task automatic test_abort();
        clr();
        push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0); push(8'h00, 1'b0);
        run_xfer(1'b0);
        n_cmp++; if (post_drive !== 1'b0) begin n_bad++; $display("FAIL abort_idle got %b want 0", post_drive); end
        arr_read(32'h0000_0012, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (rx_d[RD_OFS+i] !== mdl[18+i]) begin n_bad++;
                $display("FAIL abort_rd[%0d] got %h want %h", i, rx_d[RD_OFS+i], mdl[18+i]); end
        end
    endtask

    task automatic test_same_edge();
        arr_read(32'h0000_0014, 2, 1'b1);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (rx_d[RD_OFS+i] !== mdl[20+i]) begin n_bad++;
                $display("FAIL same_edge_rd[%0d] got %h want %h", i, rx_d[RD_OFS+i], mdl[20+i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] d [$];
        logic       m [$];
        logic [31:0] a;
        int          n, base;
        for (int t = 0; t < 12; t++) begin
            d.delete(); m.delete();
            a = $urandom;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin d.push_back(8'($urandom)); m.push_back(1'($urandom)); end
            arr_write(a, d, m);
            a = (t % 2 == 0) ? a : $urandom;
            n = $urandom_range(1, 6);
            arr_read(a, n, 1'b0);
            base = int'(a % DEPTH);
            for (int i = 0; i < n; i++) begin
                if (known[(base + i) % DEPTH]) begin
                    n_cmp++; if (rx_d[RD_OFS+i] !== mdl[(base + i) % DEPTH]) begin n_bad++;
                        $display("FAIL rand%0d_rd[%0d] addr %h got %h want %h", t, i, a,
                                 rx_d[RD_OFS+i], mdl[(base + i) % DEPTH]); end
                end
            end
        end
    endtask

    task automatic test_mr();
`ifdef PSRAM_RESP_MR_EN
        for (int k = 0; k < 8; k++) begin
            clr(); hdr(8'h40, 8'h40, 32'(k), RLC + 1); push(8'h00, 1'b0); run_xfer(1'b0);
            n_cmp++; if (rx_d[RD_OFS] !== mr_mdl[k]) begin n_bad++;
                $display("FAIL mr_dflt[%0d] got %h want %h", k, rx_d[RD_OFS], mr_mdl[k]); end
        end
        clr(); hdr(8'hC0, 8'hC0, 32'h0000_0002, 0); push(8'h5A, 1'b1); push(8'h77, 1'b1); run_xfer(1'b0);
        mr_mdl[2] = 8'h5A;
        clr(); hdr(8'h40, 8'h40, 32'hABCD_EF02, RLC + 1);
        for (int i = 0; i < 3; i++) push(8'h00, 1'b0);
        run_xfer(1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rx_d[RD_OFS+i] !== mr_mdl[2]) begin n_bad++;
                $display("FAIL mr2_rd[%0d] got %h want %h", i, rx_d[RD_OFS+i], mr_mdl[2]); end
        end
        clr(); hdr(8'hC0, 8'hC0, 32'h0000_0001, 0); push(8'h33, 1'b0); run_xfer(1'b0);
        mr_mdl[1] = 8'h33;
        clr(); hdr(8'h40, 8'h40, 32'h1, RLC + 1); push(8'h00, 1'b0); run_xfer(1'b0);
        n_cmp++; if (rx_d[RD_OFS] !== 8'h33) begin n_bad++; $display("FAIL mr1_wr got %h want 33", rx_d[RD_OFS]); end
        clr(); hdr(8'hFF, 8'hFF, 32'h0, 0); run_xfer(1'b0);
        for (int k = 0; k < 8; k++) mr_mdl[k] = (k == 1) ? 8'h0D : 8'h00;
        for (int k = 1; k < 3; k++) begin
            clr(); hdr(8'h40, 8'h40, 32'(k), RLC + 1); push(8'h00, 1'b0); run_xfer(1'b0);
            n_cmp++; if (rx_d[RD_OFS] !== mr_mdl[k]) begin n_bad++;
                $display("FAIL grst_mr[%0d] got %h want %h", k, rx_d[RD_OFS], mr_mdl[k]); end
        end
`else
        logic [7:0] opc [3];
        int         e0;
        opc[0] = 8'hC0; opc[1] = 8'h40; opc[2] = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            e0 = err_hi;
            clr(); hdr(opc[k], opc[k], 32'h2, RLC + 1); push(8'h5A, 1'b1); push(8'h77, 1'b1);
            run_xfer(1'b0);
            n_cmp++; if (err_hi - e0 != 1) begin n_bad++; $display("FAIL nomr%0d_err got %0d want 1", k, err_hi - e0); end
            foreach (rx_en[i]) begin
                n_cmp++; if (rx_en[i] !== 1'b0) begin n_bad++; $display("FAIL nomr%0d_en[%0d] got 1 want 0", k, i); end
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        rx_d.delete(); rx_hi.delete(); rx_lo.delete(); rx_en.delete(); rx_busy.delete();
`ifdef PSRAM_RESP_MR_EN
        clr(); hdr(8'hC0, 8'hC0, 32'h1, 0); push(8'h44, 1'b1); run_xfer(1'b0);
`endif
        clr(); hdr(8'h00, 8'h00, 32'h10, RLC + 1); push(8'h00, 1'b0);
        @(negedge clk); ce = 1'b0; repeat (2) @(negedge clk);
        rx_d.delete(); rx_hi.delete(); rx_lo.delete(); rx_en.delete(); rx_busy.delete();
        foreach (tx_d[i]) bus_beat(tx_d[i], 1'b0, 1'b0);
        @(negedge clk); sck = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (dqs_out !== 1'b1 || io_en !== 1'b1) begin n_bad++;
            $display("FAIL mid_pre got dqs=%b en=%b want 1 1", dqs_out, io_en); end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (io_en !== 1'b0 || dqs_en !== 1'b0) begin n_bad++;
            $display("FAIL mid_rst_en got %b%b want 00", io_en, dqs_en); end
        n_cmp++; if (dqs_out !== 1'b0 || io_out !== 8'h00) begin n_bad++;
            $display("FAIL mid_rst_out got dqs=%b io=%h want 0 00", dqs_out, io_out); end
        rst = 1'b0; sck = 1'b0;
        repeat (4) @(negedge clk);
        bus_beat(8'h00, 1'b0, 1'b0);
        n_cmp++; if (rx_en[rx_en.size()-1] !== 1'b0) begin n_bad++; $display("FAIL mid_idle got 1 want 0"); end
        @(negedge clk); ce = 1'b1; repeat (3) @(negedge clk);
        for (int k = 0; k < 8; k++) mr_mdl[k] = (k == 1) ? 8'h0D : 8'h00;
`ifdef PSRAM_RESP_MR_EN
        clr(); hdr(8'h40, 8'h40, 32'h1, RLC + 1); push(8'h00, 1'b0); run_xfer(1'b0);
        n_cmp++; if (rx_d[RD_OFS] !== mr_mdl[1]) begin n_bad++;
            $display("FAIL mid_mr1 got %h want %h", rx_d[RD_OFS], mr_mdl[1]); end
`endif
        arr_read(32'h0000_0010, 2, 1'b0);
        n_cmp++; if (rx_d[RD_OFS] !== mdl[16]) begin n_bad++;
            $display("FAIL mid_after_rd got %h want %h", rx_d[RD_OFS], mdl[16]); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin mdl[i] = 8'h00; known[i] = 1'b0; end
        for (int k = 0; k < 8; k++) mr_mdl[k] = (k == 1) ? 8'h0D : 8'h00;
        test_reset();
        test_mr();
        test_array_read();
        test_wrap_write();
        test_bad_cmd();
        test_abort();
        test_same_edge();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
